nios_pio_in_irq: RTL



---
 rtl/nios_pio_in_irq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/nios_pio_in_irq.sv
// nios_pio_in_irq -- Avalon-MM parallel input port with edge capture and IRQ.
//
// Samples external pins through a 2-flop synchronizer, latches per-bit edges
// into a write-1-to-clear edgecapture register, and raises a level IRQ when
// any captured edge is enabled in irqmask.
//
// Register map (32-bit words, bits above WIDTH read 0):
//   0 data        read-only live (synchronized) pin value
//   1 reserved    reads 0
//   2 irqmask     read/write
//   3 edgecapture read, write-1-to-clear
//
// Parameters:
//   WIDTH           number of input pins (1..32)
//   EDGE_TYPE       0 = rising, 1 = falling, 2 = any
//   DEBOUNCE_CYCLES stable cycles required before a value is accepted
//                   (only with PIO_IN_DEBOUNCE_EN)
//
// Optional feature macro: PIO_IN_DEBOUNCE_EN adds a per-bit debounce counter
// between the synchronizer and the data register.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   address            register word address
//   chipselect         slave select
//   write_n            write strobe, active low
//   writedata          write data
//   in_port            asynchronous external pins
//   readdata           combinational read data, zero wait states
//   irq                level interrupt request, active high
module nios_pio_in_irq #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1, sync2, data, prev;
  logic [WIDTH-1:0] irqmask, edgecapture;
  logic [WIDTH-1:0] edge_det, clr;
  logic [1:0]       warm;
  logic             wr_en;

  assign wr_en = chipselect & ~write_n;

  // Two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  // Per-bit debounce: a new level is accepted only after it has differed
  // from the accepted value for DEBOUNCE_CYCLES consecutive cycles; any
  // return to the accepted value restarts the count.
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    logic [15:0] cnt;
    logic        val;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
        val <= 1'b0;
      end else if (sync2[i] == val) begin
        cnt <= '0;
      end else if (cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
        val <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
    assign data[i] = val;
  end
`else
  assign data = sync2;
  logic [15:0] unused_db;
  assign unused_db = 16'(DEBOUNCE_CYCLES);
`endif

  // Warm-up: the first cycles after reset compare data against a prev that
  // has not yet caught up with the pins; suppress edges until it has, so a
  // pin held high through reset does not look like a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm <= 2'd0;
      prev <= '0;
    end else begin
      if (warm != 2'd3) warm <= warm + 2'd1;
      prev <= data;
    end
  end

  always_comb begin
    edge_det = '0;
    if (warm == 2'd3) begin
      if (EDGE_TYPE == 0)      edge_det = data & ~prev;
      else if (EDGE_TYPE == 1) edge_det = ~data & prev;
      else                     edge_det = data ^ prev;
    end
  end

  assign clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // Set has priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      edgecapture <= (edgecapture & ~clr) | edge_det;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = 32'(data);
      2'd2:    readdata = 32'(irqmask);
      2'd3:    readdata = 32'(edgecapture);
      default: readdata = '0;
    endcase
  end

  assign irq = |(edgecapture & irqmask);

  logic unused_wdata;
  assign unused_wdata = ^writedata;

endmodule
